// File: rtl/sdf_stage_ctrl_if.sv
// Handshake and control bundle between an SDF stage controller and its
// datapath / upstream source.
interface sdf_stage_ctrl_if #(
  parameter int LOG_DELAY = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 advance;
  logic                 zero_in;
  logic                 bf_en;
  logic [LOG_DELAY-1:0] tw_addr;
  logic                 out_valid;
  logic                 busy;
  logic                 err;

  // Upstream source / observer side.
  modport master (
    output in_valid,
    input  in_ready, advance, zero_in, bf_en, tw_addr, out_valid, busy, err
  );

  // Controller side.
  modport slave (
    input  in_valid,
    output in_ready, advance, zero_in, bf_en, tw_addr, out_valid, busy, err
  );
endinterface

// File: rtl/sdf_stage_ctrl.sv
// Sequencing controller for one radix-2 single-path delay-feedback FFT stage.
// Tracks the sample position within the 2*DELAY period and decodes delay-line
// shift, butterfly phase, twiddle index and output valid; after the input
// stream ends it flushes the delay line with zero input.
module sdf_stage_ctrl #(
  parameter int LOG_DELAY = 4
) (
  input  logic              clk,
  input  logic              rst,
  sdf_stage_ctrl_if.slave   bus
);

  localparam int DELAY = 1 << LOG_DELAY;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // Last position of the first half-period: the delay line is full here.
  localparam logic [LOG_DELAY:0] POS_HALF_END = (LOG_DELAY+1)'(DELAY - 1);

  logic [1:0]         state;
  logic [LOG_DELAY:0] pos;
  logic               primed;
  logic               wrapped;
  logic               err_q;

  logic               draining;
  logic               acc;
  logic               adv;

  // Control decode: everything is same-cycle with the accepted sample.
  assign draining      = (state == S_DRAIN);
  assign bus.in_ready  = !draining;
  assign acc           = bus.in_valid && !draining;
  assign adv           = acc || draining;
  assign bus.advance   = adv;
  assign bus.zero_in   = draining;
  assign bus.bf_en     = adv && pos[LOG_DELAY];
  assign bus.tw_addr   = pos[LOG_DELAY] ? '0 : pos[LOG_DELAY-1:0];
  assign bus.out_valid = adv && (primed || pos[LOG_DELAY]);
  assign bus.busy      = (state != S_IDLE);
  assign bus.err       = err_q;

  // Position counter, priming, stream-end detection and drain sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pos     <= '0;
      primed  <= 1'b0;
      wrapped <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every test below sees the pre-edge
      // pos/state; a later assignment in this block overrides an earlier one.
      if (adv) begin
        pos <= pos + 1'b1;
        if (pos == POS_HALF_END) primed <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (acc) begin
            state <= S_FILL;
          end else begin
            pos    <= '0;
            primed <= 1'b0;
          end
        end

        S_FILL: begin
          if (acc) begin
            if (pos == POS_HALF_END) state <= S_RUN;
          end else begin
            // Stream ended before a full block: always a protocol error.
            state   <= S_DRAIN;
            err_q   <= 1'b1;
            wrapped <= (pos == '0);
          end
        end

        S_RUN: begin
          if (!acc) begin
            // Legal end only on a block boundary.
            state   <= S_DRAIN;
            wrapped <= (pos == '0);
            if (pos != '0) err_q <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (wrapped && pos == POS_HALF_END) begin
            // Last delay-line entry has just left with its twiddle.
            state   <= S_IDLE;
            pos     <= '0;
            primed  <= 1'b0;
            wrapped <= 1'b0;
          end else if (pos == '1) begin
            wrapped <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Self-checking bench for sdf_stage_ctrl. The reference model describes each
// stream as "n accepted samples, one end-of-stream cycle, then a drain of
// known length", indexing every advance by its ordinal t within the stream.
module tb_sdf_stage_ctrl;

  localparam int LD = 4;
  localparam int D  = 1 << LD;
  localparam int P  = 2 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdf_stage_ctrl_if #(.LOG_DELAY(LD)) bus ();

  sdf_stage_ctrl #(.LOG_DELAY(LD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic          in_ready;
    logic          advance;
    logic          zero_in;
    logic          bf_en;
    logic [LD-1:0] tw_addr;
    logic          out_valid;
    logic          busy;
    logic          err;
  } obs_t;

  int n_checks = 0;
  int n_fail   = 0;
  bit err_model = 1'b0;

  function automatic obs_t observe();
    obs_t o;
    o.in_ready  = bus.in_ready;
    o.advance   = bus.advance;
    o.zero_in   = bus.zero_in;
    o.bf_en     = bus.bf_en;
    o.tw_addr   = bus.tw_addr;
    o.out_valid = bus.out_valid;
    o.busy      = bus.busy;
    o.err       = bus.err;
    return o;
  endfunction

  // Expected outputs on the t-th advance of a stream (t counts from 0).
  function automatic obs_t model_adv(int t, bit drain, bit e);
    obs_t o;
    int   q;
    q = t % P;
    o.in_ready  = !drain;
    o.advance   = 1'b1;
    o.zero_in   = drain;
    o.bf_en     = (q >= D);
    o.tw_addr   = (q >= D) ? '0 : LD'(q);
    o.out_valid = (t >= D);
    o.busy      = drain || (t > 0);
    o.err       = e;
    return o;
  endfunction

  // Expected outputs on a cycle with no advance at the given position.
  function automatic obs_t model_quiet(bit busy_exp, int p, bit e);
    obs_t o;
    o.in_ready  = 1'b1;
    o.advance   = 1'b0;
    o.zero_in   = 1'b0;
    o.bf_en     = 1'b0;
    o.tw_addr   = (p >= D) ? '0 : LD'(p);
    o.out_valid = 1'b0;
    o.busy      = busy_exp;
    o.err       = e;
    return o;
  endfunction

  // Drives one stream of n samples, its end cycle and its drain, checking
  // every cycle. With hold set, in_valid stays high through the drain so the
  // next stream starts on the first idle cycle.
  task automatic run_stream(input int n, input bit hold, input string tag,
                            output int ov_cnt, output int bf_cnt);
    obs_t exp_o, got;
    int   p, len;
    ov_cnt = 0;
    bf_cnt = 0;
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1 bus.in_valid = 1'b1;
      @(negedge clk);
      exp_o = model_adv(t, 1'b0, err_model);
      got   = observe();
      n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL %s input t=%0d got=%h exp=%h", tag, t, got, exp_o);
      end
      ov_cnt += int'(got.out_valid);
      bf_cnt += int'(got.bf_en);
    end

    p = n % P;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    exp_o = model_quiet(1'b1, p, err_model);
    got   = observe();
    n_checks++;
    if (got !== exp_o) begin
      n_fail++;
      $display("FAIL %s end_cycle n=%0d got=%h exp=%h", tag, n, got, exp_o);
    end
    if (p != 0) err_model = 1'b1;

    len = (p == 0) ? D : (3 * D - p);
    for (int j = 0; j < len; j++) begin
      @(posedge clk); #1 bus.in_valid = hold;
      @(negedge clk);
      exp_o = model_adv(n + j, 1'b1, err_model);
      got   = observe();
      n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL %s drain j=%0d got=%h exp=%h", tag, j, got, exp_o);
      end
      ov_cnt += int'(got.out_valid);
      bf_cnt += int'(got.bf_en);
    end

    if (!hold) begin
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(negedge clk);
      exp_o = model_quiet(1'b0, 0, err_model);
      got   = observe();
      n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL %s idle_after got=%h exp=%h", tag, got, exp_o);
      end
    end
  endtask

  task automatic test_reset();
    obs_t got, exp_o;
    bus.in_valid = 1'b0;
    #12;
    exp_o = model_quiet(1'b0, 0, 1'b0);
    got   = observe();
    n_checks++;
    if (got !== exp_o) begin
      n_fail++;
      $display("FAIL reset_values got=%h exp=%h", got, exp_o);
    end
    rst = 1'b0;
    err_model = 1'b0;
  endtask

  task automatic test_basic_block();
    int ov, bf;
    run_stream(P, 1'b0, "basic", ov, bf);
    n_checks++;
    if (ov !== 2 * D) begin
      n_fail++;
      $display("FAIL basic_ov_count got=%0d exp=%0d", ov, 2 * D);
    end
    n_checks++;
    if (bf !== D) begin
      n_fail++;
      $display("FAIL basic_bf_count got=%0d exp=%0d", bf, D);
    end
  endtask

  task automatic test_long_stream();
    int ov, bf;
    run_stream(1024, 1'b0, "long", ov, bf);
    n_checks++;
    if (ov !== 1024) begin
      n_fail++;
      $display("FAIL long_ov_count got=%0d exp=1024", ov);
    end
    n_checks++;
    if (bf !== 512) begin
      n_fail++;
      $display("FAIL long_bf_count got=%0d exp=512", bf);
    end
  endtask

  // Stream ends mid-block at pos=20: error, 28-cycle drain.
  task automatic test_misaligned_end();
    int ov, bf;
    run_stream(P + 20, 1'b0, "misaligned", ov, bf);
    n_checks++;
    if (bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned_err_sticky got=%b exp=1", bus.err);
    end
  endtask

  task automatic test_reset_mid_run();
    obs_t got, exp_o;
    int   ov, bf;
    for (int t = 0; t <= P + 25; t++) begin
      @(posedge clk); #1 bus.in_valid = 1'b1;
      @(negedge clk);
      exp_o = model_adv(t, 1'b0, err_model);
      got   = observe();
      n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL rst_mid_run t=%0d got=%h exp=%h", t, got, exp_o);
      end
    end
    #2 rst = 1'b1; bus.in_valid = 1'b0;
    #1;
    exp_o = model_quiet(1'b0, 0, 1'b0);
    got   = observe();
    n_checks++;
    if (got !== exp_o) begin
      n_fail++;
      $display("FAIL rst_mid_run_outputs got=%h exp=%h", got, exp_o);
    end
    #1 rst = 1'b0;
    err_model = 1'b0;
    run_stream(P, 1'b0, "after_rst", ov, bf);
  endtask

  // Stream ends in FILL at pos=5: error, 43-cycle drain.
  task automatic test_fill_abort();
    int ov, bf;
    run_stream(5, 1'b0, "fill_abort", ov, bf);
    n_checks++;
    if (ov !== 5 + 43 - D) begin
      n_fail++;
      $display("FAIL fill_abort_ov_count got=%0d exp=%0d", ov, 5 + 43 - D);
    end
  endtask

  task automatic test_drain_hold();
    int ov, bf;
    run_stream(2 * P, 1'b1, "drain_hold", ov, bf);
    run_stream(P, 1'b0, "after_hold", ov, bf);
  endtask

  task automatic test_random_streams();
    int ov, bf, n;
    bit hold;
    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(1, 4)) * P;
      if ($urandom_range(0, 1) == 1) n += int'($urandom_range(1, P - 1));
      hold = ($urandom_range(0, 1) == 1);
      run_stream(n, hold, "random", ov, bf);
      n_checks++;
      if (ov !== n + ((n % P == 0) ? D : 3 * D - n % P) - D) begin
        n_fail++;
        $display("FAIL random_ov_count n=%0d got=%0d", n, ov);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    test_reset();
    test_basic_block();
    test_long_stream();
    test_misaligned_end();
    test_reset_mid_run();
    test_fill_abort();
    test_drain_hold();
    test_random_streams();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
